// File: rtl/m_pcpi_master.sv
// PCPI initiator: takes one instruction plus operands on a valid/ready request port,
// drives the PicoRV32 co-processor interface, and returns the result or an abort code.
`timescale 1ns/1ps
module m_pcpi_master #(
    parameter int TIMEOUT_CYCLES  = 16,
    parameter int WATCHDOG_CYCLES = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_insn,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_wr,
    output logic [1:0]  rsp_err,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    output logic [31:0] pcpi_rs1,
    output logic [31:0] pcpi_rs2,
    input  logic        pcpi_wr,
    input  logic [31:0] pcpi_rd,
    input  logic        pcpi_busy,
    input  logic        pcpi_ready
);

    localparam int CW = $clog2(WATCHDOG_CYCLES + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_UNCLAIM  = 2'b01;
    localparam logic [1:0] ERR_WATCHDOG = 2'b10;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [31:0]   r_insn;
    logic [31:0]   r_rs1;
    logic [31:0]   r_rs2;
    logic [31:0]   r_rsp_data;
    logic          r_rsp_wr;
    logic [1:0]    r_rsp_err;
    logic [CW-1:0] r_cnt;
    logic          r_claimed;
    logic          w_claimed;
    logic [CW-1:0] w_limit_m1;
    logic          w_abort;

    // Abort limit; a busy seen this very cycle already counts as a claim.
    always_comb begin
        w_claimed  = r_claimed | pcpi_busy;
        if (w_claimed) begin
            w_limit_m1 = CW'(WATCHDOG_CYCLES - 1);
        end else begin
            w_limit_m1 = CW'(TIMEOUT_CYCLES - 1);
        end
        w_abort = (r_cnt == w_limit_m1);
    end

    // Next-state selection; pcpi_ready outranks the abort in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (pcpi_ready || w_abort) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, captured request, issue counter and registered response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_insn     <= 32'd0;
            r_rs1      <= 32'd0;
            r_rs2      <= 32'd0;
            r_rsp_data <= 32'd0;
            r_rsp_wr   <= 1'b0;
            r_rsp_err  <= ERR_OK;
            r_cnt      <= '0;
            r_claimed  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_insn    <= req_insn;
                        r_rs1     <= req_rs1;
                        r_rs2     <= req_rs2;
                        r_cnt     <= '0;
                        r_claimed <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    r_claimed <= w_claimed;
                    if (r_cnt != {CW{1'b1}}) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                    if (pcpi_ready) begin
                        r_rsp_data <= pcpi_wr ? pcpi_rd : 32'd0;
                        r_rsp_wr   <= pcpi_wr;
                        r_rsp_err  <= ERR_OK;
                    end else if (w_abort) begin
                        r_rsp_data <= 32'd0;
                        r_rsp_wr   <= 1'b0;
                        r_rsp_err  <= w_claimed ? ERR_WATCHDOG : ERR_UNCLAIM;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign pcpi_valid = (r_state == S_ISSUE);
    assign rsp_valid  = (r_state == S_RESP);
    assign pcpi_insn  = r_insn;
    assign pcpi_rs1   = r_rs1;
    assign pcpi_rs2   = r_rs2;
    assign rsp_data   = r_rsp_data;
    assign rsp_wr     = r_rsp_wr;
    assign rsp_err    = r_rsp_err;

endmodule

// File: doc/m_pcpi_master.md
Name: m_pcpi_master

Overview:
- PCPI initiator: the CPU-side issuer that drives the PicoRV32 co-processor interface toward the M/custom-instruction controller.
- Accepts one instruction and its two operands on a valid/ready request port, then drives pcpi_valid/insn/rs1/rs2.
- Waits for the co-processor's pcpi_ready, or aborts on timeout, and returns the result on a valid/ready response port.
- Used by the CPU wrapper and as a bus-attached test driver for the co-processor.

Parameters:
- TIMEOUT_CYCLES, 16: max ISSUE cycles with no pcpi_busy/pcpi_ready seen before abort (unclaimed instruction).
- WATCHDOG_CYCLES, 64: max ISSUE cycles after a claim (pcpi_busy seen) before abort. Must be greater than TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when high with req_valid
- req_insn  in  32  instruction word
- req_rs1  in  32  operand 1
- req_rs2  in  32  operand 2
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_data  out  32  result (pcpi_rd)
- rsp_wr  out  1  co-processor requested register write
- rsp_err  out  2  00 ok, 01 unclaimed timeout, 10 watchdog
- pcpi_valid  out  1  PCPI request
- pcpi_insn  out  32  PCPI instruction
- pcpi_rs1  out  32  PCPI operand 1
- pcpi_rs2  out  32  PCPI operand 2
- pcpi_wr  in  1  co-processor write flag
- pcpi_rd  in  32  co-processor result
- pcpi_busy  in  1  co-processor working
- pcpi_ready  in  1  co-processor result valid (1-cycle pulse)

Behaviour:
- Clock and reset: one clock clk; reset resetn is asynchronous, active-low.
- Reset values (apply immediately, including mid-operation): state IDLE, pcpi_valid 0, pcpi_insn/rs1/rs2 0, rsp_valid 0, rsp_data 0, rsp_wr 0, rsp_err 00, counter 0, claimed 0. req_ready reads 1 once in IDLE.
- State machine: IDLE, ISSUE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, register insn/rs1/rs2, clear counter and claimed, go to ISSUE.
- ISSUE:
  - pcpi_valid=1 (decoded from state), req_ready=0.
  - pcpi_insn/rs1/rs2 are held stable for every ISSUE cycle, including the pcpi_ready cycle; the responder reads operands combinationally when it completes.
  - claimed is set sticky when pcpi_busy=1.
  - Counter increments each ISSUE cycle, saturating.
  - Priority within a cycle: pcpi_ready > abort.
  - pcpi_ready=1: rsp_data = pcpi_wr ? pcpi_rd : 0; rsp_wr=pcpi_wr; rsp_err=00; go to RESP.
  - Else if counter == limit-1, where limit = claimed ? WATCHDOG_CYCLES : TIMEOUT_CYCLES: rsp_data=0, rsp_wr=0, rsp_err = claimed ? 10 : 01; go to RESP.
- RESP:
  - rsp_valid=1; rsp_data/wr/err stay stable until rsp_ready.
  - On rsp_ready, go to IDLE.
  - pcpi_valid=0. This guarantees pcpi_valid is low the cycle after pcpi_ready, so the responder cannot re-trigger on a stale request.
- Latency:
  - Request accepted at edge N; pcpi_valid high from cycle N+1.
  - Response valid the cycle after pcpi_ready.
  - Minimum gap between two pcpi_valid pulses: 2 cycles (RESP + IDLE).
- pcpi_ready/pcpi_busy outside ISSUE are ignored.
- pcpi_busy dropping without pcpi_ready does not clear claimed.
- req_* inputs are ignored outside IDLE.

Test Plan:
- MUL with real controller: req_insn=0x022081B3, rs1=7, rs2=6 -> rsp_data=42, rsp_wr=1, rsp_err=00; pcpi_valid low the cycle after pcpi_ready.
- DIVU with rs2=0: insn=0x0220D1B3, rs1=100 -> rsp_data=0xFFFFFFFF, rsp_err=00; rs1/rs2 stable through the pcpi_ready cycle.
- Silent responder (busy=0, ready=0), TIMEOUT_CYCLES=16 -> exactly 16 cycles of pcpi_valid, then rsp_err=01, rsp_data=0, rsp_wr=0.
- Stub holds busy=1 forever -> abort after 64 ISSUE cycles with rsp_err=10. Second case: stub pulses pcpi_ready on cycle 64 -> rsp_err=00 (ready wins the tie).
- Backpressure: rsp_ready=0 for 5 cycles with a new req_valid pending -> rsp_* stable, req_ready=0, pcpi_valid=0. New request is accepted only in the IDLE cycle after the rsp_ready handshake.
- resetn low mid-ISSUE -> pcpi_valid=0 within the same cycle, all outputs at reset values. A request issued after reset completes normally with counter restarted.
